// File: rtl/uart_cmd_parser.sv
// Parses SYNC/ADDR/DATA/CSUM command frames from a UART byte stream into
// register write strobes, with an inter-byte timeout inside a frame.
//
// state    | meaning
// IDLE     | waiting for the SYNC byte; no timeout running
// GET_ADDR | SYNC seen, next byte is the register address
// GET_DATA | address buffered, next byte is the register data
// GET_CSUM | data buffered, next byte closes the frame
module uart_cmd_parser #(
  parameter logic [7:0] SYNC    = 8'hA5,
  parameter int         TIMEOUT = 250000
) (
  input  logic       clock25,
  input  logic       reset,
  input  logic       ready,
  input  logic [7:0] rbyte,
  output logic       we,
  output logic [7:0] addr,
  output logic [7:0] data,
  output logic       err,
  output logic       busy,
  output logic [7:0] cnt_ok,
  output logic [7:0] cnt_err
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GET_ADDR = 2'd1,
    GET_DATA = 2'd2,
    GET_CSUM = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic [TW-1:0]   tmo_cnt;
  logic [7:0]      addr_buf, data_buf;
  logic [7:0]      csum_sum;
  logic            expire;
  logic            ld_addr, ld_data, commit, fail;

  // A byte in the expiry cycle wins over the timeout.
  assign expire   = (state != IDLE) && !ready && (tmo_cnt == TW'(TIMEOUT - 1));
  assign csum_sum = addr_buf + data_buf + rbyte;

  always_ff @(posedge clock25) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ld_addr   = 1'b0;
    ld_data   = 1'b0;
    commit    = 1'b0;
    fail      = 1'b0;
    case (state)
      IDLE: begin
        if (ready && rbyte == SYNC) state_nxt = GET_ADDR;
      end
      GET_ADDR: begin
        if (ready) begin
          ld_addr   = 1'b1;
          state_nxt = GET_DATA;
        end else if (expire) begin
          fail      = 1'b1;
          state_nxt = IDLE;
        end
      end
      GET_DATA: begin
        if (ready) begin
          ld_data   = 1'b1;
          state_nxt = GET_CSUM;
        end else if (expire) begin
          fail      = 1'b1;
          state_nxt = IDLE;
        end
      end
      GET_CSUM: begin
        if (ready) begin
          if (csum_sum == 8'd0) commit = 1'b1;
          else                  fail   = 1'b1;
          state_nxt = IDLE;
        end else if (expire) begin
          fail      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock25) begin
    if (reset) begin
      tmo_cnt  <= '0;
      addr_buf <= 8'd0;
      data_buf <= 8'd0;
      addr     <= 8'd0;
      data     <= 8'd0;
      we       <= 1'b0;
      err      <= 1'b0;
      busy     <= 1'b0;
      cnt_ok   <= 8'd0;
      cnt_err  <= 8'd0;
    end else begin
      we   <= commit;
      err  <= fail;
      busy <= (state_nxt != IDLE);
      if (state == IDLE || ready || expire) tmo_cnt <= '0;
      else                                  tmo_cnt <= tmo_cnt + TW'(1);
      if (ld_addr) addr_buf <= rbyte;
      if (ld_data) data_buf <= rbyte;
      if (commit) begin
        addr   <= addr_buf;
        data   <= data_buf;
        cnt_ok <= cnt_ok + 8'd1;
      end
      if (fail) cnt_err <= cnt_err + 8'd1;
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser: the driver queues expected we/err events,
// a negedge monitor pops and compares them whenever the DUT strobes.
module tb_uart_cmd_parser;

  logic       clock25 = 1'b0;
  logic       reset;
  logic       ready;
  logic [7:0] rbyte;
  logic       we, err, busy;
  logic [7:0] addr, data, cnt_ok, cnt_err;

  int n_vec = 0;
  int n_mis = 0;
  int cyc   = 0;

  typedef struct {
    bit         is_we;
    logic [7:0] a;
    logic [7:0] d;
    logic [7:0] ok;
    logic [7:0] er;
    int         at;
  } ev_t;

  ev_t exp_q[$];

  logic [7:0] m_addr = 8'd0, m_data = 8'd0, m_ok = 8'd0, m_err = 8'd0;

  uart_cmd_parser #(.SYNC(8'hA5), .TIMEOUT(8)) dut (
    .clock25 (clock25),
    .reset   (reset),
    .ready   (ready),
    .rbyte   (rbyte),
    .we      (we),
    .addr    (addr),
    .data    (data),
    .err     (err),
    .busy    (busy),
    .cnt_ok  (cnt_ok),
    .cnt_err (cnt_err)
  );

  always #20 clock25 = ~clock25;
  always @(posedge clock25) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Byte occupies the current cycle; returns that cycle number.
  task automatic put(input logic [7:0] b, output int at);
    at    = cyc;
    ready = 1'b1;
    rbyte = b;
    @(posedge clock25); #1;
    ready = 1'b0;
  endtask

  task automatic idle(input int k);
    ready = 1'b0;
    repeat (k) begin @(posedge clock25); #1; end
  endtask

  task automatic push_we(input logic [7:0] a, input logic [7:0] d, input int at);
    ev_t e;
    m_addr = a; m_data = d; m_ok = m_ok + 8'd1;
    e = '{is_we: 1'b1, a: m_addr, d: m_data, ok: m_ok, er: m_err, at: at + 1};
    exp_q.push_back(e);
  endtask

  task automatic push_err(input int at);
    ev_t e;
    m_err = m_err + 8'd1;
    e = '{is_we: 1'b0, a: m_addr, d: m_data, ok: m_ok, er: m_err, at: at + 1};
    exp_q.push_back(e);
  endtask

  task automatic frame(input logic [7:0] a, input logic [7:0] d, input logic [7:0] c);
    int t;
    put(8'hA5, t);
    put(a, t);
    put(d, t);
    put(c, t);
    if (8'(a + d + c) == 8'd0) push_we(a, d, t);
    else                       push_err(t);
  endtask

  always @(negedge clock25) begin
    if (!reset && (we || err)) begin
      chk("we_err_exclusive", {31'd0, we & err}, 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_strobe", {31'd0, we}, {31'd0, ~we});
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        chk("strobe_kind_we", {31'd0, we}, {31'd0, e.is_we});
        chk("strobe_cycle", cyc, e.at);
        chk("addr", {24'd0, addr}, {24'd0, e.a});
        chk("data", {24'd0, data}, {24'd0, e.d});
        chk("cnt_ok", {24'd0, cnt_ok}, {24'd0, e.ok});
        chk("cnt_err", {24'd0, cnt_err}, {24'd0, e.er});
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got cycle %0d, expected completion", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    reset = 1'b1;
    ready = 1'b0;
    rbyte = 8'd0;
    repeat (3) @(posedge clock25);
    #1;
    reset = 1'b0;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_we", {31'd0, we}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_addr", {24'd0, addr}, 32'd0);
    chk("rst_data", {24'd0, data}, 32'd0);
    chk("rst_cnt_ok", {24'd0, cnt_ok}, 32'd0);
    chk("rst_cnt_err", {24'd0, cnt_err}, 32'd0);
    idle(2);

    // Good frame, then bad checksum keeps addr/data.
    frame(8'h10, 8'h20, 8'hD0);
    idle(3);
    frame(8'h10, 8'h20, 8'hD1);
    idle(3);

    // Noise before SYNC, SYNC reused as address, back-to-back bytes.
    put(8'h00, t); put(8'hFF, t); put(8'hA5, t);
    put(8'hA5, t); put(8'h00, t); put(8'h5B, t);
    push_we(8'hA5, 8'h00, t);
    idle(3);

    // Timeout: 8 silent cycles after the address byte.
    put(8'hA5, t); put(8'h10, t);
    push_err(t + 8);
    idle(7);
    chk("busy_before_timeout", {31'd0, busy}, 32'd1);
    idle(1);
    chk("busy_after_timeout", {31'd0, busy}, 32'd0);
    idle(3);

    // Bytes landing exactly on the expiry cycle are processed.
    put(8'hA5, t); put(8'h10, t);
    idle(7);
    put(8'h20, t);
    idle(7);
    put(8'hD0, t);
    push_we(8'h10, 8'h20, t);
    idle(3);

    // Reset mid-frame, with a byte presented during reset.
    put(8'hA5, t); put(8'h10, t);
    reset = 1'b1; ready = 1'b1; rbyte = 8'hA5;
    @(posedge clock25); #1;
    reset = 1'b0; ready = 1'b0;
    m_addr = 8'd0; m_data = 8'd0; m_ok = 8'd0; m_err = 8'd0;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_addr", {24'd0, addr}, 32'd0);
    chk("midrst_data", {24'd0, data}, 32'd0);
    chk("midrst_cnt_ok", {24'd0, cnt_ok}, 32'd0);
    chk("midrst_cnt_err", {24'd0, cnt_err}, 32'd0);
    put(8'h20, t); put(8'hD0, t);
    idle(3);
    chk("orphan_bytes_cnt_ok", {24'd0, cnt_ok}, 32'd0);

    // 256 back-to-back good frames: SYNC overlaps each we, cnt_ok wraps.
    for (int i = 0; i < 256; i++) begin
      logic [7:0] a, d;
      a = 8'(i);
      d = a ^ 8'h3C;
      frame(a, d, 8'(8'd0 - a - d));
    end
    idle(3);
    chk("wrap_cnt_ok", {24'd0, cnt_ok}, 32'd0);
    chk("wrap_cnt_err", {24'd0, cnt_err}, 32'd0);
    chk("wrap_addr", {24'd0, addr}, 32'hFF);
    chk("pending_events", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
